// File: rtl/many_ports_initiator.sv
// Command initiator for test_module_with_many_ports: FIFO-buffered requests, one outstanding.
// Optional INITIATOR_STATS_EN adds stat_issued / stat_timeouts counters.
module many_ports_initiator #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_data,
    input  logic [3:0]  cmd_ctrl,
    output logic [7:0]  tgt_data_in,
    output logic [3:0]  tgt_control,
    output logic        tgt_enable,
    input  logic        tgt_ready,
    input  logic        tgt_valid,
    input  logic [15:0] tgt_data_out,
    input  logic [3:0]  tgt_status,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [3:0]  rsp_status,
    output logic        rsp_timeout,
    output logic        busy
`ifdef INITIATOR_STATS_EN
    ,
    output logic [15:0] stat_issued,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC) - 16'd1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic [11:0] fifo_mem [FIFO_DEPTH];
    logic [11:0] head;
    logic        empty;
    logic        full_nxt;
    logic        push;
    logic        pop;
    logic        timeout_evt;

    logic [15:0] timer_q, timer_d;
    logic [7:0]  tgt_data_q, tgt_data_d;
    logic [3:0]  tgt_ctrl_q, tgt_ctrl_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_status_q, rsp_status_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = cmd_valid && cmd_ready_q;
    assign head  = fifo_mem[rd_ptr_q[AW-1:0]];

    // FIFO pointer advance and registered not-full flag from next pointers
    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        full_nxt    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        cmd_ready_d = !full_nxt;
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= {cmd_ctrl, cmd_data};
        end
    end

    // Next-state, request latch, timer and response capture
    always_comb begin
        state_d       = state_q;
        pop           = 1'b0;
        timeout_evt   = 1'b0;
        timer_d       = timer_q;
        tgt_data_d    = tgt_data_q;
        tgt_ctrl_d    = tgt_ctrl_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    tgt_data_d = head[7:0];
                    tgt_ctrl_d = head[11:8];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (tgt_ready) begin
                    timer_d = 16'd0;
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                timer_d = timer_q + 16'd1;
                if (tgt_valid) begin
                    rsp_data_d    = tgt_data_out;
                    rsp_status_d  = tgt_status;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (TO_EN && (timer_q == TO_LAST)) begin
                    timeout_evt   = 1'b1;
                    rsp_data_d    = 16'd0;
                    rsp_status_d  = 4'hF;
                    rsp_timeout_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cmd_ready_q   <= 1'b0;
            timer_q       <= 16'd0;
            tgt_data_q    <= 8'd0;
            tgt_ctrl_q    <= 4'd0;
            rsp_data_q    <= 16'd0;
            rsp_status_q  <= 4'd0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cmd_ready_q   <= cmd_ready_d;
            timer_q       <= timer_d;
            tgt_data_q    <= tgt_data_d;
            tgt_ctrl_q    <= tgt_ctrl_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign tgt_data_in = tgt_data_q;
    assign tgt_control = tgt_ctrl_q;
    assign tgt_enable  = (state_q == ISSUE);
    assign rsp_valid   = (state_q == RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = (state_q != IDLE) || !empty;

`ifdef INITIATOR_STATS_EN
    logic [15:0] issued_q, issued_d;
    logic [15:0] touts_q, touts_d;

    // Saturating handshake and timeout counters
    always_comb begin
        issued_d = issued_q;
        touts_d  = touts_q;
        if ((state_q == ISSUE) && tgt_ready && (issued_q != 16'hFFFF)) begin
            issued_d = issued_q + 16'd1;
        end
        if (timeout_evt && (touts_q != 16'hFFFF)) begin
            touts_d = touts_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q <= 16'd0;
            touts_q  <= 16'd0;
        end else begin
            issued_q <= issued_d;
            touts_q  <= touts_d;
        end
    end

    assign stat_issued   = issued_q;
    assign stat_timeouts = touts_q;
`endif

endmodule
